// File: rtl/snitch_icache_miss_handler.sv
// rtl/snitch_icache_miss_handler.sv - icache miss handler: hit forwarding, pending-refill table, refill issue and line write-back
module snitch_icache_miss_handler #(
    parameter int unsigned FETCH_AW      = 32,
    parameter int unsigned LINE_WIDTH    = 128,
    parameter int unsigned LINE_COUNT    = 64,
    parameter int unsigned SET_COUNT     = 2,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned PENDING_COUNT = 4,
    localparam int unsigned LINE_ALIGN   = $clog2(LINE_WIDTH / 8),
    localparam int unsigned COUNT_ALIGN  = $clog2(LINE_COUNT),
    localparam int unsigned SET_ALIGN    = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
    localparam int unsigned PEND_AW      = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1,
    localparam int unsigned TAG_WIDTH    = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // lookup result
    input  logic [FETCH_AW-1:0]    in_addr_i,
    input  logic [ID_WIDTH-1:0]    in_id_i,
    input  logic [SET_ALIGN-1:0]   in_set_i,
    input  logic                   in_hit_i,
    input  logic [LINE_WIDTH-1:0]  in_data_i,
    input  logic                   in_error_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    // fetch response
    output logic [LINE_WIDTH-1:0]  out_data_o,
    output logic                   out_error_o,
    output logic [ID_WIDTH-1:0]    out_id_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    // refill request
    output logic [FETCH_AW-1:0]    refill_addr_o,
    output logic [PEND_AW-1:0]     refill_id_o,
    output logic                   refill_valid_o,
    input  logic                   refill_ready_i,
    // refill return
    input  logic [LINE_WIDTH-1:0]  refill_data_i,
    input  logic                   refill_error_i,
    input  logic [PEND_AW-1:0]     refill_id_i,
    input  logic                   refill_valid_i,
    output logic                   refill_ready_o,
    // cache write port
    output logic [COUNT_ALIGN-1:0] write_addr_o,
    output logic [SET_ALIGN-1:0]   write_set_o,
    output logic [LINE_WIDTH-1:0]  write_data_o,
    output logic [TAG_WIDTH-1:0]   write_tag_o,
    output logic                   write_error_o,
    output logic                   write_valid_o,
    input  logic                   write_ready_i
);

    localparam int unsigned LADDR_W = FETCH_AW - LINE_ALIGN;

    // pending-refill table
    logic [PENDING_COUNT-1:0] pend_valid_q;
    logic [LADDR_W-1:0]       pend_line_q [PENDING_COUNT];
    logic [ID_WIDTH-1:0]      pend_mask_q [PENDING_COUNT];

    // outstanding refill request and victim way
    logic                     req_valid_q;
    logic [FETCH_AW-1:0]      req_addr_q;
    logic [PEND_AW-1:0]       req_id_q;
    logic [SET_ALIGN-1:0]     victim_q;

    logic [LADDR_W-1:0]       in_line;
    logic                     match_found, free_found;
    logic [PEND_AW-1:0]       match_idx, free_idx;
    logic                     ret_entry;
    logic [LADDR_W-1:0]       ret_line;
    logic [ID_WIDTH-1:0]      ret_mask;
    logic                     do_merge, do_alloc, do_retire;

    // the way hint and byte offset carry no information for this stage
    logic unused_bits;
    assign unused_bits = ^{in_set_i, in_addr_i[LINE_ALIGN-1:0]};

    assign in_line = in_addr_i[FETCH_AW-1:LINE_ALIGN];

    // search the table for a line match and for the lowest free entry
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = int'(PENDING_COUNT) - 1; i >= 0; i--) begin
            if (pend_valid_q[i] && (pend_line_q[i] == in_line)) begin
                match_found = 1'b1;
                match_idx   = PEND_AW'(i);
            end
            if (!pend_valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = PEND_AW'(i);
            end
        end
    end

    // select the entry addressed by the refill return
    always_comb begin
        ret_entry = 1'b0;
        ret_line  = '0;
        ret_mask  = '0;
        for (int i = 0; i < int'(PENDING_COUNT); i++) begin
            if (refill_id_i == PEND_AW'(i)) begin
                ret_entry = pend_valid_q[i];
                ret_line  = pend_line_q[i];
                ret_mask  = pend_mask_q[i];
            end
        end
    end

    // arbitrate refill return over lookup input and steer the response port
    always_comb begin
        in_ready_o     = 1'b0;
        refill_ready_o = 1'b0;
        out_valid_o    = 1'b0;
        write_valid_o  = 1'b0;
        out_data_o     = in_data_i;
        out_error_o    = in_error_i;
        out_id_o       = in_id_i;
        do_merge       = 1'b0;
        do_alloc       = 1'b0;
        do_retire      = 1'b0;
        if (refill_valid_i) begin
            if (ret_entry) begin
                write_valid_o  = 1'b1;
                out_valid_o    = 1'b1;
                out_data_o     = refill_data_i;
                out_error_o    = refill_error_i;
                out_id_o       = ret_mask;
                refill_ready_o = write_ready_i & out_ready_i;
                do_retire      = write_ready_i & out_ready_i;
            end else begin
                // stale return for an entry lost across reset: drop it
                refill_ready_o = 1'b1;
            end
        end else if (in_hit_i) begin
            out_valid_o = in_valid_i;
            in_ready_o  = out_ready_i;
        end else if (match_found) begin
            in_ready_o = 1'b1;
            do_merge   = in_valid_i;
        end else if (free_found && !req_valid_q) begin
            in_ready_o = 1'b1;
            do_alloc   = in_valid_i;
        end
    end

    assign write_addr_o  = ret_line[COUNT_ALIGN-1:0];
    assign write_tag_o   = ret_line[LADDR_W-1:COUNT_ALIGN];
    assign write_set_o   = victim_q;
    assign write_data_o  = refill_data_i;
    assign write_error_o = refill_error_i;

    assign refill_valid_o = req_valid_q;
    assign refill_addr_o  = req_addr_q;
    assign refill_id_o    = req_id_q;

    // allocate, merge into and retire pending entries
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= '0;
            for (int i = 0; i < int'(PENDING_COUNT); i++) begin
                pend_line_q[i] <= '0;
                pend_mask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(PENDING_COUNT); i++) begin
                if (do_retire && (refill_id_i == PEND_AW'(i))) begin
                    pend_valid_q[i] <= 1'b0;
                end
                if (do_alloc && (free_idx == PEND_AW'(i))) begin
                    pend_valid_q[i] <= 1'b1;
                    pend_line_q[i]  <= in_line;
                    pend_mask_q[i]  <= in_id_i;
                end
                if (do_merge && (match_idx == PEND_AW'(i))) begin
                    pend_mask_q[i] <= pend_mask_q[i] | in_id_i;
                end
            end
        end
    end

    // hold one refill request until the refill interface accepts it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_id_q    <= '0;
        end else if (do_alloc) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= {in_line, {LINE_ALIGN{1'b0}}};
            req_id_q    <= free_idx;
        end else if (req_valid_q && refill_ready_i) begin
            req_valid_q <= 1'b0;
        end
    end

    // round-robin victim way, advanced on every completed line write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            victim_q <= '0;
        end else if (do_retire) begin
            if (victim_q == SET_ALIGN'(SET_COUNT - 1)) begin
                victim_q <= '0;
            end else begin
                victim_q <= victim_q + SET_ALIGN'(1);
            end
        end
    end

endmodule

// File: tb/tb_snitch_icache_miss_handler.sv
// tb/tb_snitch_icache_miss_handler.sv - self-checking bench for snitch_icache_miss_handler
module tb_snitch_icache_miss_handler;

    localparam int PC = 4;
    localparam int SC = 2;

    logic         clk_i, rst_ni;
    logic [31:0]  in_addr_i;
    logic [3:0]   in_id_i;
    logic [0:0]   in_set_i;
    logic         in_hit_i, in_error_i, in_valid_i, in_ready_o;
    logic [127:0] in_data_i;
    logic [127:0] out_data_o;
    logic         out_error_o, out_valid_o, out_ready_i;
    logic [3:0]   out_id_o;
    logic [31:0]  refill_addr_o;
    logic [1:0]   refill_id_o, refill_id_i;
    logic         refill_valid_o, refill_ready_i;
    logic [127:0] refill_data_i;
    logic         refill_error_i, refill_valid_i, refill_ready_o;
    logic [5:0]   write_addr_o;
    logic [0:0]   write_set_o;
    logic [127:0] write_data_o;
    logic [21:0]  write_tag_o;
    logic         write_error_o, write_valid_o, write_ready_i;

    int checks = 0;
    int errors = 0;

    // reference model: outstanding lines and the requestors waiting on them
    bit          mv [PC];
    logic [27:0] ml [PC];
    logic [3:0]  mm [PC];
    int          victim;

    snitch_icache_miss_handler dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_addr_i(in_addr_i), .in_id_i(in_id_i), .in_set_i(in_set_i), .in_hit_i(in_hit_i),
        .in_data_i(in_data_i), .in_error_i(in_error_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_error_o(out_error_o), .out_id_o(out_id_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .refill_addr_o(refill_addr_o), .refill_id_o(refill_id_o),
        .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
        .refill_data_i(refill_data_i), .refill_error_i(refill_error_i), .refill_id_i(refill_id_i),
        .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
        .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_data_o(write_data_o),
        .write_tag_o(write_tag_o), .write_error_o(write_error_o),
        .write_valid_o(write_valid_o), .write_ready_i(write_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

    function automatic int m_find(input logic [27:0] line);
        for (int i = 0; i < PC; i++) if (mv[i] && ml[i] == line) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < PC; i++) if (!mv[i]) return i;
        return -1;
    endfunction

    task automatic idle();
        in_addr_i = '0; in_id_i = '0; in_set_i = '0; in_hit_i = 0; in_data_i = '0;
        in_error_i = 0; in_valid_i = 0; out_ready_i = 1; refill_ready_i = 0;
        refill_data_i = '0; refill_error_i = 0; refill_id_i = '0; refill_valid_i = 0;
        write_ready_i = 1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 0;
        for (int i = 0; i < PC; i++) begin mv[i] = 0; ml[i] = '0; mm[i] = '0; end
        victim = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        @(posedge clk_i); #1;
    endtask

    // issue a miss; readiness, merge/allocate and refill request come from the model
    task automatic miss_check(input logic [31:0] a, input logic [3:0] id);
        logic [27:0] line;
        int m, f;
        bit exp_rdy, alloc;
        logic [1:0] fid;
        line = a[31:4];
        m = m_find(line);
        f = m_free();
        exp_rdy = (m >= 0) || (f >= 0);
        alloc = (m < 0) && (f >= 0);
        fid = f[1:0];
        in_addr_i = a; in_id_i = id; in_hit_i = 0; in_valid_i = 1;
        in_data_i = {4{$urandom}};
        #1;
        checks++;
        if (in_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL miss_ready addr=%h got %b want %b", a, in_ready_o, exp_rdy);
        end
        @(posedge clk_i); #1;
        in_valid_i = 0;
        if (exp_rdy) begin
            if (m >= 0) mm[m] = mm[m] | id;
            else begin mv[f] = 1; ml[f] = line; mm[f] = id; end
        end
        checks++;
        if (alloc) begin
            if (refill_valid_o !== 1'b1 || refill_addr_o !== {line, 4'h0} || refill_id_o !== fid) begin
                errors++;
                $display("FAIL refill_req got v=%b a=%h id=%0d want v=1 a=%h id=%0d",
                         refill_valid_o, refill_addr_o, refill_id_o, {line, 4'h0}, fid);
            end
            refill_ready_i = 1;
            @(posedge clk_i); #1;
            refill_ready_i = 0;
            checks++;
            if (refill_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL refill_clear got %b want 0", refill_valid_o);
            end
        end else if (refill_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL no_refill got %b want 0", refill_valid_o);
        end
    endtask

    // return a line for model entry k and check response plus cache write
    task automatic ret_check(input int k);
        logic [127:0] d;
        logic e;
        logic [27:0] line;
        d = {$urandom, $urandom, $urandom, $urandom};
        e = 1'($urandom_range(0, 1));
        line = ml[k];
        refill_valid_i = 1; refill_id_i = k[1:0]; refill_data_i = d; refill_error_i = e;
        out_ready_i = 1; write_ready_i = 1;
        #1;
        checks++;
        if (out_valid_o !== 1 || write_valid_o !== 1 || refill_ready_o !== 1 || in_ready_o !== 0) begin
            errors++;
            $display("FAIL ret_handshake got ov=%b wv=%b rr=%b ir=%b want 1 1 1 0",
                     out_valid_o, write_valid_o, refill_ready_o, in_ready_o);
        end
        checks++;
        if (out_id_o !== mm[k] || out_data_o !== d || out_error_o !== e) begin
            errors++;
            $display("FAIL ret_resp got id=%b err=%b data=%h want id=%b err=%b data=%h",
                     out_id_o, out_error_o, out_data_o, mm[k], e, d);
        end
        checks++;
        if (write_addr_o !== line[5:0] || write_tag_o !== line[27:6] || write_set_o !== 1'(victim) ||
            write_data_o !== d || write_error_o !== e) begin
            errors++;
            $display("FAIL ret_write got a=%h tag=%h set=%0d want a=%h tag=%h set=%0d",
                     write_addr_o, write_tag_o, write_set_o, line[5:0], line[27:6], victim);
        end
        @(posedge clk_i); #1;
        refill_valid_i = 0;
        mv[k] = 0;
        victim = (victim + 1) % SC;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        #1;
        checks++;
        if (refill_valid_o !== 0 || write_valid_o !== 0 || out_valid_o !== 0) begin
            errors++;
            $display("FAIL reset_outputs got rv=%b wv=%b ov=%b want 0 0 0",
                     refill_valid_o, write_valid_o, out_valid_o);
        end
        do_reset();
        checks++;
        if (refill_valid_o !== 0 || write_valid_o !== 0 || out_valid_o !== 0) begin
            errors++;
            $display("FAIL post_reset got rv=%b wv=%b ov=%b want 0 0 0",
                     refill_valid_o, write_valid_o, out_valid_o);
        end
    endtask

    task automatic test_hit();
        for (int i = 0; i < 8; i++) begin
            logic [127:0] d;
            logic [3:0] id;
            logic rdy, e;
            d  = (i == 0) ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
            id = (i == 0) ? 4'b0001 : 4'(1 << $urandom_range(0, 3));
            rdy = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            e  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            in_addr_i = (i == 0) ? 32'h1000 : $urandom; in_id_i = id; in_hit_i = 1;
            in_data_i = d; in_error_i = e; in_valid_i = 1; out_ready_i = rdy;
            #1;
            checks++;
            if (out_valid_o !== 1 || out_id_o !== id || out_data_o !== d || out_error_o !== e || in_ready_o !== rdy) begin
                errors++;
                $display("FAIL hit_fwd[%0d] got ov=%b id=%b err=%b ir=%b data=%h want 1 %b %b %b %h",
                         i, out_valid_o, out_id_o, out_error_o, in_ready_o, out_data_o, id, e, rdy, d);
            end
            @(posedge clk_i); #1;
            checks++;
            if (refill_valid_o !== 0 || write_valid_o !== 0) begin
                errors++;
                $display("FAIL hit_no_refill got rv=%b wv=%b want 0 0", refill_valid_o, write_valid_o);
            end
        end
        in_valid_i = 0; out_ready_i = 1;
        #1;
        checks++;
        if (out_valid_o !== 0) begin
            errors++;
            $display("FAIL hit_idle got ov=%b want 0", out_valid_o);
        end
        in_hit_i = 0;
    endtask

    task automatic test_miss();
        do_reset();
        miss_check(32'h2010, 4'b0001);
        ret_check(0);
    endtask

    task automatic test_merge();
        miss_check(32'h3000, 4'b0001);
        miss_check(32'h3008, 4'b0010);
        checks++;
        if (mm[0] !== 4'b0011) begin
            errors++;
            $display("FAIL merge_model got %b want 0011", mm[0]);
        end
        ret_check(0);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) miss_check(32'h4000 + 32'(i * 16), 4'(1 << i));
        in_addr_i = 32'h4100; in_id_i = 4'b1000; in_hit_i = 0; in_valid_i = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready_o !== 0) begin
                errors++;
                $display("FAIL full_stall[%0d] got %b want 0", c, in_ready_o);
            end
            @(posedge clk_i); #1;
        end
        in_valid_i = 0;
        ret_check(1);
        miss_check(32'h4100, 4'b1000);
        for (int i = 0; i < PC; i++) if (mv[i]) ret_check(i);
    endtask

    task automatic test_back_to_back();
        logic [127:0] h;
        do_reset();
        miss_check(32'h5000, 4'b0100);
        h = {$urandom, $urandom, $urandom, $urandom};
        refill_valid_i = 1; refill_id_i = 2'd0; refill_data_i = {4{32'hCAFE0000}}; refill_error_i = 0;
        out_ready_i = 0; write_ready_i = 1;
        in_addr_i = 32'h6000; in_id_i = 4'b1000; in_hit_i = 1; in_data_i = h; in_error_i = 0; in_valid_i = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (refill_ready_o !== 0 || in_ready_o !== 0 || out_valid_o !== 1 || out_id_o !== 4'b0100) begin
                errors++;
                $display("FAIL b2b_stall[%0d] got rr=%b ir=%b ov=%b id=%b want 0 0 1 0100",
                         c, refill_ready_o, in_ready_o, out_valid_o, out_id_o);
            end
            @(posedge clk_i); #1;
        end
        out_ready_i = 1;
        #1;
        checks++;
        if (refill_ready_o !== 1 || out_data_o !== {4{32'hCAFE0000}} || write_set_o !== 1'(victim)) begin
            errors++;
            $display("FAIL b2b_return got rr=%b set=%0d data=%h want 1 %0d cafe..",
                     refill_ready_o, write_set_o, out_data_o, victim);
        end
        @(posedge clk_i); #1;
        refill_valid_i = 0; mv[0] = 0; victim = (victim + 1) % SC;
        #1;
        checks++;
        if (out_valid_o !== 1 || out_id_o !== 4'b1000 || out_data_o !== h || in_ready_o !== 1 || write_valid_o !== 0) begin
            errors++;
            $display("FAIL b2b_hit got ov=%b id=%b ir=%b wv=%b want 1 1000 1 0",
                     out_valid_o, out_id_o, in_ready_o, write_valid_o);
        end
        @(posedge clk_i); #1;
        in_valid_i = 0; in_hit_i = 0;
    endtask

    task automatic test_stale();
        do_reset();
        miss_check(32'h7000, 4'b0001);
        do_reset();
        refill_valid_i = 1; refill_id_i = 2'd0; refill_data_i = '1;
        #1;
        checks++;
        if (refill_ready_o !== 1 || write_valid_o !== 0 || out_valid_o !== 0) begin
            errors++;
            $display("FAIL stale_drop got rr=%b wv=%b ov=%b want 1 0 0",
                     refill_ready_o, write_valid_o, out_valid_o);
        end
        @(posedge clk_i); #1;
        refill_valid_i = 0;
        miss_check(32'h7000, 4'b0010);
        ret_check(0);
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 60; it++) begin
            int np;
            np = 0;
            for (int i = 0; i < PC; i++) if (mv[i]) np++;
            if (np > 0 && $urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, PC - 1);
                while (!mv[k]) k = (k + 1) % PC;
                ret_check(k);
            end else begin
                logic [27:0] line;
                line = 28'h0000300 + 28'($urandom_range(0, 5));
                miss_check({line, 4'($urandom_range(0, 15))}, 4'(1 << $urandom_range(0, 3)));
            end
        end
        for (int i = 0; i < PC; i++) if (mv[i]) ret_check(i);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_merge();
        test_full();
        test_back_to_back();
        test_stale();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
